switch_conditioner: RTL and testbench
=====================================

// Module: switch_conditioner
// PURPOSE
//   Upstream conditioning stage for the slide-switch bank on the board.
//   - Synchronises each raw switch into the clk domain with a 2-FF chain, then debounces each bit independently.
//   - sw_clean replaces raw sw as the input to the circuit_a -> circuit_b chain that drives led.
//   - Also emits one-cycle rise/fall strobes per bit for edge-driven logic added later.
// PARAMETERS
//   WIDTH            7          number of switch bits conditioned
//   DEBOUNCE_CYCLES  1_000_000  stable cycles required before accepting a new level (10 ms @ 100 MHz); legal range >= 2
//   CNT_W            $clog2(DEBOUNCE_CYCLES)  counter width; localparam, not overridable
// PORTS
//   clk       input   1      board clock; all logic on rising edge
//   btnC      input   1      reset, synchronous, active-high
//   sw        input   WIDTH  raw asynchronous switch levels
//   sw_clean  output  WIDTH  synchronised, debounced switch levels
//   sw_rise   output  WIDTH  1-cycle pulse per bit when sw_clean[i] goes 0->1
//   sw_fall   output  WIDTH  1-cycle pulse per bit when sw_clean[i] goes 1->0
//   changed   output  1      OR of all sw_rise and sw_fall bits (combinational from registered strobes)
// BEHAVIOUR
//   Reset (btnC high at a rising edge)
//   - sync1, sync2, sw_clean, all counters, sw_rise and sw_fall are cleared to 0.
//   - Reset has priority over all other updates.
//   - Reset asserted mid-count discards partial counts; no strobe is produced on that edge.
//   Synchroniser
//   - sync1 <= sw; sync2 <= sync1.
//   - Only sync2 is used downstream; raw sw never reaches the debounce logic.
//   Per-bit debounce (independent for each i)
//   - The 2-state FSM per bit is encoded by (sync2[i] == sw_clean[i]):
//     - STABLE (equal): cnt[i] <= 0.
//     - PENDING (differ), cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
//     - PENDING, cnt[i] == DEBOUNCE_CYCLES-1: sw_clean[i] <= sync2[i]; cnt[i] <= 0; the matching strobe is set for that cycle.
//   - Any return of sync2[i] to sw_clean[i] before terminal count returns the bit to STABLE and clears cnt[i]. A glitch shorter than DEBOUNCE_CYCLES is fully rejected.
//   - The counter never wraps; the terminal compare is exact.
//   Latency
//   - Count the first rising edge that samples a new stable raw level as edge 1.
//   - sw_clean updates at edge DEBOUNCE_CYCLES+2.
//   Strobes
//   - sw_rise[i] and sw_fall[i] are registered and high for exactly one cycle, on the same edge sw_clean[i] updates.
//   - They are never both high for the same bit. Multiple bits may strobe on the same cycle.
//   Power-up / reset with switches already on
//   - sw_clean starts at 0, then follows the normal debounce path.
//   - This produces sw_rise pulses DEBOUNCE_CYCLES+2 edges after reset deasserts.
// TESTING  (bench uses DEBOUNCE_CYCLES=4)
//   1. btnC=1 for 2 cycles, sw=7'h7F -> sw_clean=0, strobes=0 during reset; after release, sw_clean=7'h7F and sw_rise=7'h7F for 1 cycle on edge 6 after release.
//   2. From sw_clean=0, set sw[0]=1 and hold -> sw_clean[0]=1 at edge 6; sw_rise=7'h01 and changed=1 for exactly one cycle; no other bit moves.
//   3. Glitch: sw[3]=1 for 3 cycles, then 0 -> sw_clean stays 0; sw_rise and changed never assert.
//   4. Simultaneous: sw goes 7'h00 -> 7'h55 on one edge, and later 7'h55 -> 7'h50 -> sw_rise=7'h55 on a single cycle, then sw_fall=7'h05 on a single cycle; each strobe is 1 cycle wide.
//   5. Reset mid-operation: set sw[6]=1, pulse btnC at edge 4 -> no sw_rise on edge 4 or 5; counting restarts; sw_clean[6]=1 at edge 6 after btnC deasserts.
//   6. Chatter: toggle sw[2] every 2 cycles for 40 cycles, then hold at 1 -> no change during chatter; single sw_rise[2] at edge 6 after the last transition.

Source files
------------

// File: rtl/switch_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : switch_conditioner
// Description : 2-FF synchroniser plus per-bit debounce for the slide-switch
//               bank, with one-cycle rise/fall strobes per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_conditioner #(
  parameter int WIDTH           = 7,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             btnC,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed
);

  localparam int              CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_clean;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] w_pending;

  // A bit is pending whenever the synchronised level disagrees with the accepted one.
  assign w_pending = r_sync2 ^ r_clean;

  always_ff @(posedge clk) begin
    if (btnC) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_clean <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= sw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < WIDTH; i++) begin
        r_rise[i] <= 1'b0;
        r_fall[i] <= 1'b0;
        if (!w_pending[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == c_TERM) begin
          r_clean[i] <= r_sync2[i];
          r_cnt[i]   <= '0;
          r_rise[i]  <= r_sync2[i];
          r_fall[i]  <= ~r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign sw_clean = r_clean;
  assign sw_rise  = r_rise;
  assign sw_fall  = r_fall;
  assign changed  = |{r_rise, r_fall};

endmodule
`default_nettype wire

// File: tb/tb_switch_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_conditioner
// Description : Scoreboard bench for switch_conditioner with a run-length
//               reference model, directed scenarios and random switch traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_conditioner;

  localparam int W = 7;
  localparam int D = 4;

  typedef struct packed {
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         chg;
  } exp_t;

  logic         clk = 1'b0;
  logic         btnC = 1'b1;
  logic [W-1:0] sw = '0;
  logic [W-1:0] sw_clean;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         changed;

  int checks = 0;
  int errors = 0;

  exp_t expq[$];
  bit   started = 1'b0;

  switch_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .btnC     (btnC),
    .sw       (sw),
    .sw_clean (sw_clean),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .changed  (changed)
  );

  always #5 clk = ~clk;

  // Reference model: raw levels travel through a two-deep history, and a bit
  // is accepted once its delayed level has disagreed for D consecutive edges.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_clean;
  int           run [W];

  initial begin
    hist    = '{'0, '0};
    m_clean = '0;
    for (int i = 0; i < W; i++) run[i] = 0;
  end

  always @(posedge clk) begin
    exp_t         e;
    logic [W-1:0] s2;
    e.rise = '0;
    e.fall = '0;
    if (btnC) begin
      hist    = '{'0, '0};
      m_clean = '0;
      for (int i = 0; i < W; i++) run[i] = 0;
    end else begin
      s2 = hist.pop_front();
      hist.push_back(sw);
      for (int i = 0; i < W; i++) begin
        if (s2[i] != m_clean[i]) begin
          run[i] = run[i] + 1;
          if (run[i] == D) begin
            m_clean[i] = s2[i];
            if (s2[i]) e.rise[i] = 1'b1;
            else       e.fall[i] = 1'b1;
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
    end
    e.clean = m_clean;
    e.chg   = |{e.rise, e.fall};
    expq.push_back(e);
    started = 1'b1;
  end

  // Monitor: one expected record per edge, compared on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: no expected record at t=%0t", $time);
      end else begin
        e = expq.pop_front();
        if (sw_clean !== e.clean || sw_rise !== e.rise || sw_fall !== e.fall || changed !== e.chg) begin
          errors++;
          $display("FAIL scoreboard t=%0t: got clean=%h rise=%h fall=%h chg=%b, expected clean=%h rise=%h fall=%h chg=%b",
                   $time, sw_clean, sw_rise, sw_fall, changed, e.clean, e.rise, e.fall, e.chg);
        end
      end
    end
  end

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic dcheck(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  initial begin
    // 1: reset with all switches on, then power-up acceptance on edge D+2
    sw   = 7'h7F;
    btnC = 1'b1;
    cycles(2);
    #1;
    dcheck("reset_clean", sw_clean, 7'h00);
    dcheck("reset_rise", sw_rise, 7'h00);
    @(negedge clk);
    btnC = 1'b0;
    cycles(D + 1);
    dcheck("pwrup_clean_before", sw_clean, 7'h00);
    cycles(1);
    dcheck("pwrup_clean", sw_clean, 7'h7F);
    dcheck("pwrup_rise", sw_rise, 7'h7F);
    cycles(1);
    dcheck("pwrup_rise_gone", sw_rise, 7'h00);

    // 2: single bit rise
    sw = 7'h00;
    cycles(10);
    sw = 7'h01;
    cycles(D + 1);
    dcheck("bit0_before", sw_clean, 7'h00);
    cycles(1);
    dcheck("bit0_clean", sw_clean, 7'h01);
    dcheck("bit0_rise", sw_rise, 7'h01);
    dcheck("bit0_changed", {6'b0, changed}, 7'h01);
    cycles(1);
    dcheck("bit0_changed_gone", {6'b0, changed}, 7'h00);
    sw = 7'h00;
    cycles(10);

    // 3: glitch shorter than the debounce window
    sw = 7'h08;
    cycles(3);
    sw = 7'h00;
    cycles(10);
    dcheck("glitch_clean", sw_clean, 7'h00);

    // 4: simultaneous rise then partial fall
    sw = 7'h55;
    cycles(10);
    sw = 7'h50;
    cycles(10);
    dcheck("multi_clean", sw_clean, 7'h50);
    sw = 7'h00;
    cycles(10);

    // 5: reset mid-count restarts the debounce
    sw = 7'h40;
    cycles(3);
    btnC = 1'b1;
    cycles(1);
    btnC = 1'b0;
    cycles(D + 1);
    dcheck("midreset_before", sw_clean, 7'h00);
    cycles(1);
    dcheck("midreset_clean", sw_clean, 7'h40);
    sw = 7'h00;
    cycles(10);

    // 6: chatter then settle high
    for (int k = 0; k < 20; k++) begin
      sw[2] = ~sw[2];
      cycles(2);
    end
    sw[2] = 1'b1;
    cycles(10);
    dcheck("chatter_clean", sw_clean, 7'h04);

    // Random traffic with occasional resets
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 99) < 3) begin
        btnC = 1'b1;
        cycles($urandom_range(1, 2));
        btnC = 1'b0;
      end
      if ($urandom_range(0, 1) == 0) sw = W'($urandom);
      else                           sw[$urandom_range(0, W - 1)] ^= 1'b1;
      cycles($urandom_range(1, 8));
    end
    cycles(10);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d records left, expected 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
